crossbar_accumulator: RTL and testbench
=======================================

Name: crossbar_accumulator

Overview:
- Downstream stage of the 4x4 crossbar multiply cell.
- Consumes a stream of unsigned 8-bit products, one per handshake, and accumulates them into a dot-product sum with saturation.
- A vector closes after VEC_LEN products or on an early last flag; the result is then presented on a valid/ready output port.
- Sits between the crossbar cell array and the activation/writeback logic.

Parameters:
- PROD_W, 8, width of incoming product (matches crossbar cell result width).
- ACC_W, 10, accumulator and output sum width; must be >= PROD_W.
- VEC_LEN, 8, products per dot product; must be >= 1.
- CNT_W, 4, width of count output; must hold VEC_LEN (clog2(VEC_LEN+1)).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- prod_valid  in  1  product on prod_data is valid.
- prod_ready  out  1  block accepts a product this cycle.
- prod_data  in  PROD_W  unsigned product.
- prod_last  in  1  qualifies prod_data as the final product of the current vector (early close).
- sum_valid  out  1  sum_data/sum_sat/sum_count valid.
- sum_ready  in  1  downstream accepts the sum.
- sum_data  out  ACC_W  accumulated sum (saturated).
- sum_sat  out  1  saturation occurred during this vector.
- sum_count  out  CNT_W  number of products in this vector.
- busy  out  1  high when in ACCUM or HOLD.

Behaviour:
- Interface: one clock, `clock`; reset `reset_n` is asynchronous and active-low.
- Reset (asserted at any time, including mid-vector or while HOLD is pending):
  - state=IDLE; acc=0, cnt=0, sat=0.
  - sum_valid=0, sum_data=0, sum_sat=0, sum_count=0, busy=0.
  - prod_ready=1 on the first cycle after deassertion.
  - The partial vector is discarded.
- Accept = prod_valid & prod_ready. Pop = sum_valid & sum_ready.
- prod_ready = (state != HOLD) | sum_ready. Combinational from sum_ready only; no dependence on prod_valid.
- Add rule: next = acc + prod_data, computed at ACC_W+1 bits. If next > 2^ACC_W-1, then acc = 2^ACC_W-1 and sat=1. sat is sticky until the vector is popped.
- IDLE:
  - On accept: acc=prod_data, cnt=1, sat=0.
  - If prod_last or VEC_LEN==1, go to HOLD; else go to ACCUM.
- ACCUM:
  - On accept: apply add rule, cnt=cnt+1.
  - If cnt+1==VEC_LEN or prod_last, go to HOLD.
  - No accept: hold all state; bubbles are allowed.
- HOLD:
  - sum_valid=1; sum_data=acc, sum_sat=sat, sum_count=cnt, all registered.
  - Outputs stay stable while !sum_ready.
  - Pop without accept: go to IDLE, sum_valid=0.
  - Pop with accept in the same cycle: the new product starts a fresh vector with the IDLE-accept rules. Next state is ACCUM, or HOLD if it is last or VEC_LEN==1. No bubble.
- Latency: sum_valid rises on the clock edge that accepts the closing product, i.e. visible the cycle after the accept. Throughput is one product per cycle sustained.
- prod_last while in HOLD without pop: not accepted, since prod_ready=0. The upstream must hold the product.
- prod_last with cnt already at VEC_LEN-1: the vector closes once; the two conditions do not double-count.
- busy = (state != IDLE).
- No X propagation: prod_data is ignored when prod_valid=0.

Test Plan:
1. Reset: hold reset_n=0 with prod_valid=1, prod_data=200 -> sum_valid=0, sum_data=0, busy=0; prod_ready=1 after release; no accumulation of the held data.
2. Full vector: 8 back-to-back products 10,20,...,80, sum_ready=1 -> sum_valid for exactly one cycle, the cycle after the 8th accept; sum_data=360, sum_count=8, sum_sat=0; prod_ready stays 1 throughout.
3. Saturation: 8 products of 225 -> sum_data=1023, sum_sat=1, sum_count=8; next vector of 1,1 with last -> sum_data=2, sum_sat=0.
4. Early close: products 5 then 7 with prod_last=1 on 7 -> sum_data=12, sum_count=2; a bubble cycle between them (prod_valid=0) changes nothing.
5. Backpressure: close vector sum=360, sum_ready=0 for 5 cycles with prod_valid=1, prod_data=9 -> outputs stable, prod_ready=0, nothing accepted. Then sum_ready=1 in the same cycle -> pop and accept together; next vector starts with acc=9, cnt=1.
6. Reset mid-vector: after 3 products of 50, pulse reset_n low for 1 cycle (async, off-edge) -> state IDLE; the following 8 products of 1 give sum_data=8, sum_count=8.

Source files
------------

// File: rtl/crossbar_accumulator_if.sv
// Product-in / sum-out handshake bundle for the crossbar accumulator.
// slave is the accumulator side, master is the producer/consumer side.
interface crossbar_accumulator_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 10,
    parameter int unsigned CNT_W  = 4
);
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod_data;
    logic              prod_last;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_data;
    logic              sum_sat;
    logic [CNT_W-1:0]  sum_count;
    logic              busy;

    modport slave (
        input  prod_valid, prod_data, prod_last, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_sat, sum_count, busy
    );

    modport master (
        output prod_valid, prod_data, prod_last, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_sat, sum_count, busy
    );
endinterface

// File: rtl/crossbar_accumulator.sv
// Saturating dot-product accumulator: sums a stream of unsigned products into
// vectors of VEC_LEN (or closed early by prod_last) and presents each sum downstream.
module crossbar_accumulator #(
    parameter int unsigned PROD_W  = 8,
    parameter int unsigned ACC_W   = 10,
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    crossbar_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [ACC_W-1:0] AccMax = '1;

    state_e             r_state;
    state_e             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;

    logic               w_prod_ready;
    logic               w_accept;
    logic               w_pop;
    logic               w_close_first;
    logic               w_close_accum;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [ACC_W:0]     w_sum;

    assign w_prod_ready  = (r_state != StHold) | bus.sum_ready;
    assign w_accept      = bus.prod_valid & w_prod_ready;
    assign w_pop         = (r_state == StHold) & bus.sum_ready;
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_close_first = bus.prod_last | (VEC_LEN == 1);
    assign w_close_accum = bus.prod_last | (w_cnt_inc == CNT_W'(VEC_LEN));
    assign w_sum         = {1'b0, r_acc} + (ACC_W + 1)'(bus.prod_data);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = w_close_first ? StHold : StAccum;
            end
            StAccum: begin
                if (w_accept && w_close_accum) w_state_next = StHold;
            end
            StHold: begin
                // A pop may coincide with the first product of the next vector.
                if (w_pop) begin
                    if (w_accept) w_state_next = w_close_first ? StHold : StAccum;
                    else          w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.prod_ready = w_prod_ready;
        bus.sum_valid  = (r_state == StHold);
        bus.busy       = (r_state != StIdle);
        bus.sum_data   = r_acc;
        bus.sum_sat    = r_sat;
        bus.sum_count  = r_cnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            if (r_state == StAccum) begin
                if (w_sum[ACC_W]) begin
                    r_acc <= AccMax;
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
                r_cnt <= w_cnt_inc;
            end else begin
                r_acc <= ACC_W'(bus.prod_data);
                r_cnt <= CNT_W'(1);
                r_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crossbar_accumulator.sv
// Directed plus randomized bench for crossbar_accumulator against a
// transaction-level model of completed vectors.
module tb_crossbar_accumulator;

    localparam int PROD_W  = 8;
    localparam int ACC_W   = 10;
    localparam int VEC_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int MAXV    = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   npass = 0;

    // Model: partial vector being built and the completed vector awaiting pop.
    int   p_sum = 0, p_cnt = 0;
    bit   p_sat = 0;
    bit   m_pend = 0;
    int   m_sum = 0, m_cnt = 0;
    bit   m_sat = 0;

    crossbar_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    crossbar_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .VEC_LEN(VEC_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        p_sum = 0; p_cnt = 0; p_sat = 0;
        m_pend = 0; m_sum = 0; m_cnt = 0; m_sat = 0;
    endtask

    // Drive one cycle, check outputs before the edge, advance the model at the edge.
    task automatic step(input bit v, input int d, input bit l, input bit sr);
        bit acc_ok;
        bit pop;
        bus.prod_valid = v;
        bus.prod_data  = v ? d[PROD_W-1:0] : 8'hxx;
        bus.prod_last  = l;
        bus.sum_ready  = sr;
        #1;
        chk("prod_ready", 32'(bus.prod_ready), 32'(!m_pend || sr));
        chk("sum_valid", 32'(bus.sum_valid), 32'(m_pend));
        chk("busy", 32'(bus.busy), 32'(m_pend || p_cnt > 0));
        if (m_pend) begin
            chk("sum_data", 32'(bus.sum_data), 32'(m_sum));
            chk("sum_sat", 32'(bus.sum_sat), 32'(m_sat));
            chk("sum_count", 32'(bus.sum_count), 32'(m_cnt));
        end
        acc_ok = v && (!m_pend || sr);
        pop    = m_pend && sr;
        @(posedge clk);
        if (pop) m_pend = 0;
        if (acc_ok) begin
            p_sum += d;
            if (p_sum > MAXV) begin
                p_sum = MAXV;
                p_sat = 1;
            end
            p_cnt++;
            if (p_cnt == VEC_LEN || l) begin
                m_pend = 1; m_sum = p_sum; m_cnt = p_cnt; m_sat = p_sat;
                p_sum = 0; p_cnt = 0; p_sat = 0;
            end
        end
        #1;
    endtask

    initial begin
        bus.prod_valid = 1'b1;
        bus.prod_data  = 8'd200;
        bus.prod_last  = 1'b0;
        bus.sum_ready  = 1'b1;

        // Reset held with a valid product present.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst_sum_data", 32'(bus.sum_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum_count", 32'(bus.sum_count), 32'd0);
        bus.prod_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 1);

        // Full vector 10..80.
        for (int i = 1; i <= 8; i++) step(1, 10 * i, 0, 1);
        chk("full_data", 32'(bus.sum_data), 32'd360);
        chk("full_count", 32'(bus.sum_count), 32'd8);
        step(0, 0, 0, 1);
        chk("full_valid_once", 32'(bus.sum_valid), 32'd0);

        // Saturation, then a fresh short vector clears sat.
        for (int i = 0; i < 8; i++) step(1, 225, 0, 1);
        chk("sat_data", 32'(bus.sum_data), 32'd1023);
        chk("sat_flag", 32'(bus.sum_sat), 32'd1);
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        chk("post_sat_data", 32'(bus.sum_data), 32'd2);
        chk("post_sat_flag", 32'(bus.sum_sat), 32'd0);
        step(0, 0, 0, 1);

        // Early close with a bubble in between.
        step(1, 5, 0, 1);
        step(0, 99, 1, 1);
        step(1, 7, 1, 1);
        chk("early_data", 32'(bus.sum_data), 32'd12);
        chk("early_count", 32'(bus.sum_count), 32'd2);
        step(0, 0, 0, 1);

        // Backpressure, then pop and accept in the same cycle.
        for (int i = 1; i <= 8; i++) step(1, 10 * i, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 9, 1, 0);
        chk("bp_data_stable", 32'(bus.sum_data), 32'd360);
        step(1, 9, 1, 1);
        chk("bp_new_data", 32'(bus.sum_data), 32'd9);
        chk("bp_new_count", 32'(bus.sum_count), 32'd1);
        step(0, 0, 0, 1);

        // Reset pulse mid-vector, off-edge.
        for (int i = 0; i < 3; i++) step(1, 50, 0, 1);
        bus.prod_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_count", 32'(bus.sum_count), 32'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1);
        chk("midrst_data", 32'(bus.sum_data), 32'd8);
        chk("midrst_cnt8", 32'(bus.sum_count), 32'd8);
        step(0, 0, 0, 1);

        // Randomized traffic with bubbles, early lasts and backpressure.
        for (int i = 0; i < 400; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
